// File: rtl/alu_serial_port.sv
// alu_serial_port: operand serializer and result deserializer for the bit-serial ALU.
// Takes one 8/16-bit operand over valid/ready, streams it LSB-first NSHIFT bits per
// cycle into the ALU, collects the serial result, and offers it over valid/ready.
module alu_serial_port #(
  parameter int REG_BITS  = 8,
  parameter int NSHIFT    = 2,
  parameter int WORD_BITS = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [WORD_BITS-1:0]                   in_data,
  input  logic                                   in_pair,
  output logic                                   alu_op_valid,
  input  logic                                   alu_op_done,
  output logic [NSHIFT-1:0]                      alu_data_in,
  input  logic [NSHIFT-1:0]                      alu_data_out,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [WORD_BITS-1:0]                   res_data,
  output logic [$clog2(WORD_BITS/NSHIFT):0]      res_beats,
  output logic                                   proto_err
);

  localparam int BW = $clog2(WORD_BITS/NSHIFT) + 1;
  localparam logic [BW-1:0] PAIR_BEATS   = BW'(WORD_BITS/NSHIFT);
  localparam logic [BW-1:0] SINGLE_BEATS = BW'(REG_BITS/NSHIFT);
  localparam logic [WORD_BITS-1:0] LOW_MASK =
    {{(WORD_BITS-REG_BITS){1'b0}}, {REG_BITS{1'b1}}};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;

  logic [1:0]           state;
  logic                 pair;
  logic [WORD_BITS-1:0] operand_sr;
  logic [WORD_BITS-1:0] result_sr;
  logic [BW-1:0]        beats;

  logic                 accept;
  logic [WORD_BITS-1:0] nxt_sr;
  logic [BW-1:0]        nxt_beats;
  logic [BW-1:0]        limit;
  logic [WORD_BITS-1:0] aligned;
  int                   shamt;

  assign alu_op_valid = (state == SHIFT);
  assign res_valid    = (state == RESULT);
  assign alu_data_in  = operand_sr[NSHIFT-1:0];
  assign res_beats    = beats;

  // Handshake decode and next-beat capture/alignment values.
  always_comb begin
    in_ready  = (state == IDLE) || ((state == RESULT) && res_ready);
    accept    = in_valid && in_ready;
    nxt_sr    = {alu_data_out, result_sr[WORD_BITS-1:NSHIFT]};
    nxt_beats = beats + BW'(1);
    limit     = pair ? PAIR_BEATS : SINGLE_BEATS;
    // Captured beats sit at the top of the register; shift them down so the
    // first beat lands at bit 0 regardless of how many beats actually arrived.
    shamt     = NSHIFT * (int'(PAIR_BEATS) - int'(nxt_beats));
    aligned   = nxt_sr >> shamt;
    if (!pair) aligned = aligned & LOW_MASK;
  end

  // Operation sequencing, operand/result shifting and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pair       <= 1'b0;
      operand_sr <= '0;
      result_sr  <= '0;
      beats      <= '0;
      res_data   <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (alu_op_done && (state != SHIFT)) proto_err <= 1'b1;
      if (accept) begin
        operand_sr <= in_pair ? in_data
                              : {{(WORD_BITS-REG_BITS){1'b0}}, in_data[REG_BITS-1:0]};
        pair       <= in_pair;
        result_sr  <= '0;
        beats      <= '0;
        res_data   <= '0;
        state      <= SHIFT;
      end else begin
        case (state)
          IDLE: ;
          SHIFT: begin
            operand_sr <= operand_sr >> NSHIFT;
            result_sr  <= nxt_sr;
            beats      <= nxt_beats;
            if (alu_op_done || (nxt_beats == limit)) begin
              state    <= RESULT;
              res_data <= aligned;
              if (!alu_op_done) proto_err <= 1'b1;
            end
          end
          RESULT: if (res_ready) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_port.sv
// Directed self-checking bench for alu_serial_port.
module tb_alu_serial_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_pair;
  logic        alu_op_valid;
  logic        alu_op_done;
  logic [1:0]  alu_data_in;
  logic [1:0]  alu_data_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_beats;
  logic        proto_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  seq [16];
  int          nbeats;
  logic [1:0]  exp_pair_seq [8] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
  logic [15:0] held;

  alu_serial_port #(.REG_BITS(8), .NSHIFT(2), .WORD_BITS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_pair(in_pair), .alu_op_valid(alu_op_valid),
    .alu_op_done(alu_op_done), .alu_data_in(alu_data_in), .alu_data_out(alu_data_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_beats(res_beats), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Play the ALU while alu_op_valid is high: echo or constant 2'b11 data,
  // done raised on beat done_beat (0 = never). Bounded to 12 cycles.
  task automatic shift_phase(input bit echo, input int done_beat, output int nb);
    nb = 0;
    for (int c = 0; c < 12 && alu_op_valid; c++) begin
      if (nb < 16) seq[nb] = alu_data_in;
      alu_data_out = echo ? alu_data_in : 2'b11;
      nb++;
      alu_op_done = (nb == done_beat);
      tick();
    end
    alu_op_done = 1'b0;
  endtask

  // Offer one operand from IDLE, scramble inputs after accept, then shift.
  task automatic run_op(input logic [15:0] d, input logic p, input bit echo,
                        input int done_beat, output int nb);
    in_data = d; in_pair = p; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 16'hFFFF; in_pair = ~p;
    shift_phase(echo, done_beat, nb);
  endtask

  task automatic drain();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_pair = 1'b0;
    alu_op_done = 1'b0; alu_data_out = '0; res_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_op_valid", 32'(alu_op_valid), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_beats", 32'(res_beats), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);

    // Single op 0x00A5, echo, done on beat 4.
    run_op(16'h00A5, 1'b0, 1'b1, 4, nbeats);
    chk("s_beats_seen", 32'(nbeats), 32'd4);
    chk("s_seq0", 32'(seq[0]), 32'd1);
    chk("s_seq1", 32'(seq[1]), 32'd1);
    chk("s_seq2", 32'(seq[2]), 32'd2);
    chk("s_seq3", 32'(seq[3]), 32'd2);
    chk("s_res_valid", 32'(res_valid), 32'd1);
    chk("s_res_data", 32'(res_data), 32'h00A5);
    chk("s_res_beats", 32'(res_beats), 32'd4);
    chk("s_proto_err", 32'(proto_err), 32'd0);
    drain();
    chk("s_drain_valid", 32'(res_valid), 32'd0);
    chk("s_drain_ready", 32'(in_ready), 32'd1);

    // Pair op 0x1234, echo, done on beat 8.
    run_op(16'h1234, 1'b1, 1'b1, 8, nbeats);
    chk("p_beats_seen", 32'(nbeats), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("p_seq%0d", i), 32'(seq[i]), 32'(exp_pair_seq[i]));
    chk("p_res_data", 32'(res_data), 32'h1234);
    chk("p_res_beats", 32'(res_beats), 32'd8);
    chk("p_proto_err", 32'(proto_err), 32'd0);
    drain();

    // Early done: pair, data_out 2'b11, done on beat 3.
    run_op(16'h5555, 1'b1, 1'b0, 3, nbeats);
    chk("e_beats_seen", 32'(nbeats), 32'd3);
    chk("e_res_data", 32'(res_data), 32'h003F);
    chk("e_res_beats", 32'(res_beats), 32'd3);
    chk("e_proto_err", 32'(proto_err), 32'd0);

    // Backpressure for 5 cycles, then back-to-back accept of 0x0011.
    held = 16'h003F;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_res_data", 32'(res_data), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0011; in_pair = 1'b0;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    tick();
    res_ready = 1'b0; in_valid = 1'b0;
    chk("b2b_op_valid", 32'(alu_op_valid), 32'd1);
    chk("b2b_res_valid", 32'(res_valid), 32'd0);
    shift_phase(1'b1, 4, nbeats);
    chk("b2b_beats_seen", 32'(nbeats), 32'd4);
    chk("b2b_res_data", 32'(res_data), 32'h0011);
    drain();

    // alu_op_done in IDLE sets sticky proto_err.
    alu_op_done = 1'b1;
    tick();
    alu_op_done = 1'b0;
    chk("idle_done_err", 32'(proto_err), 32'd1);
    tick(); tick();
    chk("idle_done_sticky", 32'(proto_err), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("err_cleared", 32'(proto_err), 32'd0);

    // Single op with no done: forced RESULT after 4 beats.
    run_op(16'h003C, 1'b0, 1'b1, 0, nbeats);
    chk("ov_beats_seen", 32'(nbeats), 32'd4);
    chk("ov_res_valid", 32'(res_valid), 32'd1);
    chk("ov_res_beats", 32'(res_beats), 32'd4);
    chk("ov_res_data", 32'(res_data), 32'h003C);
    chk("ov_proto_err", 32'(proto_err), 32'd1);
    drain();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Reset in SHIFT at beat 2.
    in_data = 16'h00FF; in_pair = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    alu_data_out = 2'b10;
    tick(); tick();
    chk("mid_beats", 32'(res_beats), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_op_valid", 32'(alu_op_valid), 32'd0);
    chk("mid_res_valid", 32'(res_valid), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_res_beats", 32'(res_beats), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
